// File: rtl/rto_event_scheduler_pkg.sv
// Shared types and widths for the timed-release event scheduler.
package rto_pkg;

    localparam int TS_W   = 64;
    localparam int DATA_W = 128;

    typedef struct packed {
        logic [63:0] timestamp;
        logic [63:0] payload;
    } rto_entry_t;

endpackage

// File: rtl/rto_event_scheduler_if.sv
// Write-side and release-side signals between the front end and the scheduler.
interface rto_event_scheduler_if;
    import rto_pkg::*;

    logic              write;
    logic [DATA_W-1:0] fifo_din;
    logic              counter_matched;
    logic [DATA_W-1:0] rto_out;
    logic              full;
    logic              empty;

    modport master (
        output write, fifo_din,
        input  counter_matched, rto_out, full, empty
    );

    modport slave (
        input  write, fifo_din,
        output counter_matched, rto_out, full, empty
    );

endinterface

// File: rtl/rto_event_scheduler_sync_fifo.sv
// Synchronous FIFO with registered read data; storage is reset-free for block RAM inference.
module rto_sync_fifo #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
        if (rd_en) dout <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
        end
    end

endmodule

// File: rtl/rto_event_scheduler.sv
// Timed-release buffer: the head entry is released when the global counter reaches its timestamp.
module rto_event_scheduler
    import rto_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH),
    parameter int DATA_W     = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  auto_start,
    input  logic                  flush,
    input  logic [TS_W-1:0]       counter,
    rto_event_scheduler_if.slave  bus,
    output logic                  timestamp_error,
    output logic [DATA_W-1:0]     timestamp_error_data,
    output logic                  overflow_error,
    output logic [DATA_W-1:0]     overflow_error_data
);

    logic [ADDR_W:0]   fifo_count;
    logic [ADDR_W:0]   occupancy;
    logic [DATA_W-1:0] head_entry;
    logic [TS_W-1:0]   head_ts;
    logic              head_valid;
    logic              is_full, is_empty;
    logic              release_ok, match, late, pop;
    logic              rd_en, wr_en, ovf;
    logic              matched_q;
    logic [DATA_W-1:0] rto_out_q;

    // The FIFO's registered read port doubles as the head register; head_valid tracks it.
    rto_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .wr_en (wr_en),
        .din   (bus.fifo_din),
        .rd_en (rd_en),
        .dout  (head_entry),
        .count (fifo_count)
    );

    always_comb begin
        head_ts    = head_entry[DATA_W-1 -: TS_W];
        occupancy  = fifo_count + (ADDR_W+1)'(head_valid);
        is_full    = (occupancy == (ADDR_W+1)'(FIFO_DEPTH));
        is_empty   = (occupancy == '0);
        release_ok = auto_start && head_valid && !flush;
        match      = release_ok && (head_ts == counter);
        late       = release_ok && (head_ts < counter);
        pop        = match || late;
        rd_en      = (fifo_count != '0) && (!head_valid || pop) && !flush;
        wr_en      = bus.write && !is_full && !flush;
        ovf        = bus.write && is_full && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      head_valid <= 1'b0;
        else if (flush) head_valid <= 1'b0;
        else if (rd_en) head_valid <= 1'b1;
        else if (pop)   head_valid <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matched_q            <= 1'b0;
            rto_out_q            <= '0;
            timestamp_error      <= 1'b0;
            timestamp_error_data <= '0;
            overflow_error       <= 1'b0;
            overflow_error_data  <= '0;
        end else begin
            matched_q <= match;
            if (match) rto_out_q <= head_entry;
            if (late) begin
                timestamp_error <= 1'b1;
                if (!timestamp_error) timestamp_error_data <= head_entry;
            end
            if (ovf) begin
                overflow_error <= 1'b1;
                if (!overflow_error) overflow_error_data <= bus.fifo_din;
            end
        end
    end

    assign bus.counter_matched = matched_q;
    assign bus.rto_out         = rto_out_q;
    assign bus.full            = is_full;
    assign bus.empty           = is_empty;

endmodule

// File: tb/tb_rto_event_scheduler.sv
// Directed self-checking bench for rto_event_scheduler.
module tb_rto_event_scheduler;
    import rto_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         auto_start;
    logic         flush;
    logic [63:0]  counter;
    logic         timestamp_error;
    logic [127:0] timestamp_error_data;
    logic         overflow_error;
    logic [127:0] overflow_error_data;
    int           tests = 0;
    int           fails = 0;

    rto_event_scheduler_if bus ();

    rto_event_scheduler #(
        .FIFO_DEPTH (512),
        .DATA_W     (128)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .auto_start           (auto_start),
        .flush                (flush),
        .counter              (counter),
        .bus                  (bus),
        .timestamp_error      (timestamp_error),
        .timestamp_error_data (timestamp_error_data),
        .overflow_error       (overflow_error),
        .overflow_error_data  (overflow_error_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [63:0] ts, input logic [63:0] pl);
        rto_entry_t e;
        e.timestamp = ts;
        e.payload   = pl;
        return e;
    endfunction

    task automatic wr(input logic [63:0] ts, input logic [63:0] pl);
        bus.write    = 1'b1;
        bus.fifo_din = mk(ts, pl);
        tick();
        bus.write    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++; if (bus.counter_matched !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b exp 0", bus.counter_matched); end
        tests++; if (bus.rto_out !== '0) begin fails++; $display("FAIL reset_rto_out got %h exp 0", bus.rto_out); end
        tests++; if (timestamp_error !== 1'b0 || overflow_error !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", timestamp_error, overflow_error); end
        tests++; if (timestamp_error_data !== '0 || overflow_error_data !== '0) begin fails++; $display("FAIL reset_err_data got %h/%h exp 0", timestamp_error_data, overflow_error_data); end
        tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL reset_empty_full got e=%b f=%b exp e=1 f=0", bus.empty, bus.full); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_release();
        logic exp;
        auto_start = 1'b1;
        counter    = 64'd90;
        wr(64'd100, 64'hA1);
        wr(64'd105, 64'hA2);
        for (int c = 90; c <= 110; c++) begin
            counter = 64'(c);
            tick();
            exp = (c == 100) || (c == 105);
            tests++; if (bus.counter_matched !== exp) begin fails++; $display("FAIL release_strobe c=%0d got %b exp %b", c, bus.counter_matched, exp); end
            if (exp) begin
                tests++; if (bus.rto_out !== mk(64'(c), (c == 100) ? 64'hA1 : 64'hA2)) begin fails++; $display("FAIL release_data c=%0d got %h", c, bus.rto_out); end
            end
        end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL release_empty got %b exp 1", bus.empty); end
        tests++; if (timestamp_error !== 1'b0) begin fails++; $display("FAIL release_no_ts_err got %b exp 0", timestamp_error); end
    endtask

    task automatic test_late();
        logic exp;
        auto_start = 1'b1;
        counter    = 64'd60;
        wr(64'd50, 64'hB1);
        wr(64'd70, 64'hB2);
        for (int c = 60; c <= 75; c++) begin
            counter = 64'(c);
            tick();
            exp = (c == 70);
            tests++; if (bus.counter_matched !== exp) begin fails++; $display("FAIL late_strobe c=%0d got %b exp %b", c, bus.counter_matched, exp); end
        end
        tests++; if (bus.rto_out !== mk(64'd70, 64'hB2)) begin fails++; $display("FAIL late_rto_out got %h", bus.rto_out); end
        tests++; if (timestamp_error !== 1'b1) begin fails++; $display("FAIL late_flag got %b exp 1", timestamp_error); end
        tests++; if (timestamp_error_data !== mk(64'd50, 64'hB1)) begin fails++; $display("FAIL late_data got %h exp %h", timestamp_error_data, mk(64'd50, 64'hB1)); end
    endtask

    task automatic test_flush();
        auto_start = 1'b0;
        for (int i = 0; i < 10; i++) wr(64'(3000 + i), 64'(i));
        tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL flush_prefill got empty=%b exp 0", bus.empty); end
        flush        = 1'b1;
        bus.write    = 1'b1;
        bus.fifo_din = mk(64'd7, 64'hC0);
        tick();
        flush     = 1'b0;
        bus.write = 1'b0;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL flush_empty got %b exp 1", bus.empty); end
        tests++; if (timestamp_error !== 1'b1 || overflow_error !== 1'b0) begin fails++; $display("FAIL flush_flags got ts=%b ov=%b exp ts=1 ov=0", timestamp_error, overflow_error); end
        auto_start = 1'b1;
        counter    = 64'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.counter_matched !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL flush_absent got strobe=%b empty=%b exp 0/1", bus.counter_matched, bus.empty); end
        end
        tests++; if (bus.rto_out !== mk(64'd70, 64'hB2)) begin fails++; $display("FAIL flush_rto_out got %h", bus.rto_out); end
    endtask

    task automatic test_reset_mid();
        auto_start = 1'b1;
        counter    = 64'd200;
        wr(64'd300, 64'hD0);
        wr(64'd301, 64'hD1);
        wr(64'd302, 64'hD2);
        tick();
        counter = 64'd300;
        #2 reset = 1'b1;
        #1;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rstmid_async_empty got %b exp 1", bus.empty); end
        tick();
        reset = 1'b0;
        tick();
        tests++; if (bus.counter_matched !== 1'b0) begin fails++; $display("FAIL rstmid_strobe got %b exp 0", bus.counter_matched); end
        tests++; if (bus.rto_out !== '0 || timestamp_error !== 1'b0 || timestamp_error_data !== '0) begin fails++; $display("FAIL rstmid_outputs got rto=%h ts=%b", bus.rto_out, timestamp_error); end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rstmid_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_overflow();
        auto_start = 1'b0;
        counter    = 64'd0;
        for (int i = 0; i < 512; i++) wr(64'(2000 + i), 64'(i));
        tests++; if (bus.full !== 1'b1 || overflow_error !== 1'b0) begin fails++; $display("FAIL ovf_fill got full=%b ov=%b exp 1/0", bus.full, overflow_error); end
        wr(64'hDEAD, 64'h55);
        tests++; if (overflow_error !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow_error); end
        tests++; if (overflow_error_data !== mk(64'hDEAD, 64'h55)) begin fails++; $display("FAIL ovf_data got %h", overflow_error_data); end
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", bus.full); end
        wr(64'hBEEF, 64'h66);
        tests++; if (overflow_error_data !== mk(64'hDEAD, 64'h55)) begin fails++; $display("FAIL ovf_first_only got %h", overflow_error_data); end
    endtask

    task automatic test_full_release();
        test_reset();
        auto_start = 1'b0;
        counter    = 64'd0;
        for (int i = 0; i < 512; i++) wr(64'(1000 + i), 64'(i));
        tick();
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fullrel_full got %b exp 1", bus.full); end
        counter    = 64'd1000;
        auto_start = 1'b1;
        wr(64'hF00D, 64'h1);
        auto_start = 1'b0;
        tests++; if (bus.counter_matched !== 1'b1) begin fails++; $display("FAIL fullrel_strobe got %b exp 1", bus.counter_matched); end
        tests++; if (bus.rto_out !== mk(64'd1000, 64'd0)) begin fails++; $display("FAIL fullrel_data got %h", bus.rto_out); end
        tests++; if (overflow_error !== 1'b1 || overflow_error_data !== mk(64'hF00D, 64'h1)) begin fails++; $display("FAIL fullrel_ovf got %b %h", overflow_error, overflow_error_data); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL fullrel_not_full got %b exp 0", bus.full); end
        tick();
        tests++; if (bus.counter_matched !== 1'b0) begin fails++; $display("FAIL fullrel_one_cycle got %b exp 0", bus.counter_matched); end
        wr(64'd5000, 64'h2);
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fullrel_refill got %b exp 1", bus.full); end
    endtask

    initial begin
        reset        = 1'b1;
        auto_start   = 1'b0;
        flush        = 1'b0;
        counter      = '0;
        bus.write    = 1'b0;
        bus.fifo_din = '0;
        test_reset();
        test_release();
        test_late();
        test_flush();
        test_reset_mid();
        test_overflow();
        test_full_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
